// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Groups the fetch stage's handshake and bus signals.
//   - imem request  : imem_req_valid/ready/addr (fetch -> memory)
//   - imem response : imem_rsp_valid/data       (memory -> fetch, no backpressure)
//   - redirect      : redirect_valid/pc         (back end -> fetch)
//   - decode output : inst_valid/ready, inst, pc (fetch -> decode)
//   modport master : the fetch unit's view
//   modport slave  : the environment's view (memory, back end, decode)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Holds the fetch PC, issues in-order 32-bit word
//   requests, buffers returned words with their PCs in a first-word
//   fall-through FIFO and hands them to decode. A redirect flushes the FIFO and
//   marks every outstanding request as stale so its response is dropped.
// Ports
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : fetch_unit_if.master (imem request/response, redirect, decode side)
// -----------------------------------------------------------------------------

// Invariant checks on the credit scheme and the memory contract.
module fetch_unit_chk #(
  parameter int unsigned CW        = 3,
  parameter int unsigned BUF_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic          rsp_valid,
  input logic [CW-1:0] count,
  input logic [CW-1:0] pend
);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> ({1'b0, count} < DEPTH_W));

  a_credit: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, pend} + {1'b0, count}) <= DEPTH_W);

  a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
    rsp_valid |-> (pend != {CW{1'b0}}));
endmodule

module fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter int unsigned BUF_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int unsigned PW      = $clog2(BUF_DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_rsp_pc;
  logic [CW-1:0] r_pend;
  logic [CW-1:0] r_stale;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_buf_inst [BUF_DEPTH];
  logic [63:0]   r_buf_pc   [BUF_DEPTH];

  logic          w_credit;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_stale_any;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_pend_next;
  logic [CW-1:0] w_count_next;
  logic [63:0]   w_redir_pc;

  // Outstanding requests plus buffered words may never exceed the FIFO size,
  // which guarantees every live response has a free slot.
  assign w_credit    = ({1'b0, r_pend} + {1'b0, r_count}) < DEPTH_W;
  // Gated by rst so the request line is quiet while reset is held.
  assign w_req_valid = !rst && !bus.redirect_valid && w_credit;
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;
  assign w_stale_any = (r_stale != {CW{1'b0}});
  assign w_push      = bus.imem_rsp_valid && !bus.redirect_valid && !w_stale_any;
  // A pop in a redirect cycle is ignored; the flush wins.
  assign w_pop       = (r_count != {CW{1'b0}}) && bus.inst_ready && !bus.redirect_valid;
  assign w_redir_pc  = {bus.redirect_pc[63:2], 2'b00};

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = (r_count != {CW{1'b0}});
  assign bus.inst           = r_buf_inst[r_rd_ptr];
  assign bus.pc             = r_buf_pc[r_rd_ptr];

  // Pending-count bookkeeping: +1 per accepted request, -1 per response (live or stale).
  always_comb begin
    w_pend_next = r_pend;
    case ({w_req_fire, bus.imem_rsp_valid})
      2'b10:   w_pend_next = r_pend + CNT_ONE;
      2'b01:   w_pend_next = r_pend - CNT_ONE;
      default: w_pend_next = r_pend;
    endcase
  end

  // FIFO occupancy update for push/pop combinations.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Fetch state, FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_pend     <= {CW{1'b0}};
      r_stale    <= {CW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_wr_ptr   <= {PW{1'b0}};
      r_rd_ptr   <= {PW{1'b0}};
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_inst[i] <= 32'h0000_0000;
        r_buf_pc[i]   <= 64'h0000_0000_0000_0000;
      end
    end else begin
      r_pend <= w_pend_next;
      if (bus.redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old path.
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        r_stale    <= w_pend_next;
        r_count    <= {CW{1'b0}};
        r_wr_ptr   <= {PW{1'b0}};
        r_rd_ptr   <= {PW{1'b0}};
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 64'd4;
        end else begin
          r_fetch_pc <= r_fetch_pc;
        end
        if (bus.imem_rsp_valid && w_stale_any) begin
          r_stale <= r_stale - CNT_ONE;
        end else begin
          r_stale <= r_stale;
        end
        if (w_push) begin
          r_buf_inst[r_wr_ptr] <= bus.imem_rsp_data;
          r_buf_pc[r_wr_ptr]   <= r_rsp_pc;
          r_wr_ptr             <= r_wr_ptr + PTR_ONE;
          r_rsp_pc             <= r_rsp_pc + 64'd4;
        end else begin
          r_wr_ptr <= r_wr_ptr;
          r_rsp_pc <= r_rsp_pc;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end else begin
          r_rd_ptr <= r_rd_ptr;
        end
        r_count <= w_count_next;
      end
    end
  end

  fetch_unit_chk #(.CW(CW), .BUF_DEPTH(BUF_DEPTH)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .rsp_valid (bus.imem_rsp_valid),
    .count     (r_count),
    .pend      (r_pend)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit. A memory model answers requests in order after a
//   programmable latency; an expected-instruction queue is filled from the
//   current program-order PC and reset on every redirect/reset; a monitor pops
//   it on every decode handshake and compares pc/inst.
//   Timing: inputs change at negedge (+0/+1), memory samples at +3, monitor
//   and directed checks at +3/+4, posedge at +5.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic clk;
  logic rst;
  fetch_unit_if ifc ();

  fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  logic [63:0] acc_log[$];
  logic [63:0] gen_pc;
  int          cyc      = 0;
  int          lat      = 1;
  bit          rand_lat = 1'b0;
  int          pop_cnt  = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model; also tops up the expected program-order stream.
  initial begin
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      while (exp_q.size() < 8) begin
        exp_q.push_back('{pc: gen_pc, inst: word_of(gen_pc)});
        gen_pc = gen_pc + 64'd4;
      end
      if (!rst && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = word_of(mem_q[0].addr);
      end else begin
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_data  = 32'h0;
      end
      #3;
      if (rst) begin
        mem_q.delete();
        ifc.imem_rsp_valid = 1'b0;
      end else begin
        if (ifc.imem_rsp_valid) void'(mem_q.pop_front());
        if (ifc.imem_req_valid && ifc.imem_req_ready) begin
          mem_q.push_back('{addr: ifc.imem_req_addr, due: cyc + lat});
          acc_log.push_back(ifc.imem_req_addr);
          if (rand_lat) lat = $urandom_range(1, 4);
        end
      end
    end
  end

  // Monitor: compare every word decode accepts against the expected stream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && ifc.inst_valid && ifc.inst_ready && !ifc.redirect_valid) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", ifc.pc, e.pc);
          check("sb_inst", {32'h0, ifc.inst}, {32'h0, e.inst});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_reset();
    rst = 1'b1;
    exp_q.delete();
    acc_log.delete();
    gen_pc = RESET_PC;
    ifc.imem_req_ready = 1'b0;
    ifc.inst_ready     = 1'b0;
    ifc.redirect_valid = 1'b0;
    rand_lat = 1'b0;
    lat      = 1;
  endtask

  task automatic apply_reset();
    #1;
    start_reset();
    tick(2);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [63:0] tgt);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = tgt;
    exp_q.delete();
    gen_pc = {tgt[63:2], 2'b00};
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
  endtask

  initial begin
    int p0;
    int a0;
    bit found;
    ifc.redirect_pc = 64'h0;
    start_reset();

    // Reset state
    tick(2);
    #3;
    check("rst_req_valid", {63'h0, ifc.imem_req_valid}, 64'd0);
    check("rst_req_addr", ifc.imem_req_addr, RESET_PC);
    check("rst_inst_valid", {63'h0, ifc.inst_valid}, 64'd0);
    check("rst_inst", {32'h0, ifc.inst}, 64'd0);
    check("rst_pc", ifc.pc, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: streaming, 1-cycle latency
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b1;
    tick(10);
    for (int i = 0; i < 4; i++) check("t1_addr", acc_log[i], RESET_PC + 64'(4 * i));
    p0 = pop_cnt;
    tick(20);
    check("t1_no_bubbles", 64'(pop_cnt - p0), 64'd20);

    // 2: decode stall fills the FIFO
    apply_reset();
    ifc.imem_req_ready = 1'b1;
    tick(20);
    #3;
    check("t2_accepted", 64'(acc_log.size()), 64'd4);
    check("t2_full_valid", {63'h0, ifc.inst_valid}, 64'd1);
    check("t2_req_blocked", {63'h0, ifc.imem_req_valid}, 64'd0);
    check("t2_head_pc", ifc.pc, RESET_PC);
    @(negedge clk);
    p0 = pop_cnt;
    ifc.inst_ready = 1'b1;
    tick(10);
    check("t2_drained", 64'(pop_cnt - p0 >= 4), 64'd1);
    check("t2_resumed", 64'(acc_log.size() > 4), 64'd1);

    // 3: redirect with three requests in flight
    apply_reset();
    lat = 10;
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b1;
    tick(3);
    check("t3_inflight", 64'(mem_q.size()), 64'd3);
    lat = 1;
    a0 = acc_log.size();
    do_redirect(64'h0000_0000_8000_1002);
    #3;
    check("t3_no_req_in_redirect", 64'(acc_log.size()), 64'(a0));
    check("t3_req_valid", {63'h0, ifc.imem_req_valid}, 64'd1);
    check("t3_req_addr", ifc.imem_req_addr, 64'h0000_0000_8000_1000);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      #4;
      if (ifc.inst_valid) found = 1'b1;
    end
    check("t3_first_found", {63'h0, found}, 64'd1);
    check("t3_first_pc", ifc.pc, 64'h0000_0000_8000_1000);

    // 4: redirect coinciding with a response and a pop
    apply_reset();
    lat = 2;
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b1;
    tick(6);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      #1;
      if (ifc.imem_rsp_valid && ifc.inst_valid) found = 1'b1;
    end
    check("t4_setup", {63'h0, found}, 64'd1);
    p0 = pop_cnt;
    do_redirect(64'h0000_0000_9000_0000);
    #1;
    check("t4_flushed", {63'h0, ifc.inst_valid}, 64'd0);
    check("t4_stale", 64'(dut.r_stale), 64'(mem_q.size()));
    tick(20);
    check("t4_progress", 64'(pop_cnt - p0 >= 10), 64'd1);

    // 5: random traffic and redirects
    apply_reset();
    rand_lat = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      ifc.imem_req_ready = ($urandom_range(0, 3) != 0);
      ifc.inst_ready     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) do_redirect({$urandom, $urandom});
    end
    check("t5_progress", 64'(pop_cnt - p0 > 1000), 64'd1);

    // 6: reset with a full-ish FIFO and a pending request
    apply_reset();
    ifc.imem_req_ready = 1'b1;
    tick(3);
    lat = 30;
    tick(3);
    #3;
    check("t6_setup_count", {63'h0, ifc.inst_valid}, 64'd1);
    check("t6_setup_pend", 64'(mem_q.size()), 64'd1);
    @(negedge clk);
    #1;
    start_reset();
    #3;
    check("t6_inst_valid", {63'h0, ifc.inst_valid}, 64'd0);
    check("t6_req_valid", {63'h0, ifc.imem_req_valid}, 64'd0);
    @(negedge clk);
    #3;
    check("t6_inst_valid_next", {63'h0, ifc.inst_valid}, 64'd0);
    check("t6_req_valid_next", {63'h0, ifc.imem_req_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b1;
    p0 = pop_cnt;
    tick(10);
    check("t6_restart_addr", acc_log[0], RESET_PC);
    check("t6_restart_pops", 64'(pop_cnt - p0 >= 5), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
